// File: rtl/mem_dump_tx_pkg.sv
// mem_dump_tx_pkg: shared constants and state encoding for the memory dump framer
package mem_dump_tx_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS = 10;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int FRAME_BYTES = NUM_WORDS * DATA_WIDTH / 8 + 2;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, CSUM = 2'd3} state_t;
endpackage

// File: rtl/mem_dump_tx_if.sv
// mem_dump_tx_if: valid/ready byte stream toward the UART transmitter
interface mem_dump_tx_if;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] tx_data;
  modport master(output tx_valid, output tx_data, input tx_ready);
  modport slave(input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: snapshots the memory debug bus and streams header, data bytes and XOR checksum
module mem_dump_tx #(
  parameter int DATA_WIDTH = mem_dump_tx_pkg::DATA_WIDTH,
  parameter int NUM_WORDS = mem_dump_tx_pkg::NUM_WORDS,
  parameter logic [7:0] HEADER_BYTE = mem_dump_tx_pkg::HEADER_BYTE
) (
  input  logic clka,
  input  logic reset,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] memorias,
  input  logic start,
  mem_dump_tx_if.master tx,
  output logic busy,
  output logic done
);
  import mem_dump_tx_pkg::*;
  localparam int BITS = NUM_WORDS * DATA_WIDTH;
  localparam int LAST = BITS / 8 - 1;
  state_t state;
  logic [BITS-1:0] snap;
  logic [5:0] idx;
  logic [7:0] csum;
  logic acc;
  logic last;
  assign acc = tx.tx_valid && tx.tx_ready;
  assign last = idx == 6'(LAST);
  // snap shifts left on each accept so the next byte is always in the top 8 bits
  always_ff @(posedge clka) begin
    if (reset) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      csum <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      tx.tx_valid <= 1'b0;
      tx.tx_data <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start && !done) begin
          snap <= memorias;
          busy <= 1'b1;
          tx.tx_valid <= 1'b1;
          tx.tx_data <= HEADER_BYTE;
          state <= HDR;
        end
        HDR: if (acc) begin
          tx.tx_data <= snap[BITS-1 -: 8];
          snap <= snap << 8;
          idx <= '0;
          csum <= '0;
          state <= DATA;
        end
        DATA: if (acc) begin
          csum <= csum ^ tx.tx_data;
          idx <= idx + 6'd1;
          tx.tx_data <= last ? csum ^ tx.tx_data : snap[BITS-1 -: 8];
          snap <= snap << 8;
          state <= last ? CSUM : DATA;
        end
        CSUM: if (acc) begin
          tx.tx_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
